fpga_ofm_capture: RTL and testbench



---
 rtl/fpga_ofm_capture.sv | 156 +++++++++++++++
 tb/tb_fpga_ofm_capture.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_ofm_capture.sv
// Capture engine for ASIC write transfers: FSM, FWFT capture FIFO, beat count and checksum.
// Optional beat-pattern checking is compiled in with OFM_CAPTURE_CHK_EN.
module fpga_ofm_capture #(
  parameter int unsigned FLGOFM_WORDS = 64,
  parameter int unsigned OFM_WORDS    = 64,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned TIMEOUT_CYC  = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [3:0]   ifcode,
  input  logic         wr_val,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  input  logic         pop,
  output logic [127:0] pop_data,
  output logic         empty,
  output logic         busy,
  output logic         done,
  output logic [19:0]  word_cnt,
  output logic [31:0]  checksum,
  output logic         err_code,
  output logic         err_timeout,
  output logic [15:0]  mismatch_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {StIdle, StArm, StCapture, StDone} state_e;

  state_e        state_q, state_d;
  logic [AW:0]   wr_ptr_q, rd_ptr_q, count;
  logic [127:0]  mem_q [FIFO_DEPTH];
  logic [19:0]   target_q, target_d;
  logic [19:0]   cnt_q, cnt_d;
  logic [31:0]   sum_q, sum_d;
  logic [TW-1:0] idle_q, idle_d;
  logic          err_code_q, err_code_d;
  logic          err_to_q, err_to_d;
  logic          accept, pop_ok, start_ok;
  logic [31:0]   fold;

  assign count    = wr_ptr_q - rd_ptr_q;
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign wr_rdy   = (state_q == StCapture) && (count < (AW + 1)'(FIFO_DEPTH));
  assign accept   = wr_rdy && wr_val;
  assign pop_ok   = pop && !empty;
  assign start_ok = (state_q == StIdle) && start && (ifcode == 4'd1 || ifcode == 4'd2);
  assign fold     = wr_data[31:0] ^ wr_data[63:32] ^ wr_data[95:64] ^ wr_data[127:96];

  assign pop_data    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign word_cnt    = cnt_q;
  assign checksum    = sum_q;
  assign err_code    = err_code_q;
  assign err_timeout = err_to_q;

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    idle_d     = idle_q;
    err_code_d = err_code_q;
    err_to_d   = err_to_q;
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d  = StArm;
          target_d = (ifcode == 4'd1) ? 20'(FLGOFM_WORDS) : 20'(OFM_WORDS);
          cnt_d    = '0;
          sum_d    = '0;
        end else if (start) begin
          err_code_d = 1'b1;
        end
      end
      StArm: begin
        state_d = StCapture;
        idle_d  = '0;
      end
      StCapture: begin
        if (accept) begin
          cnt_d  = cnt_q + 20'd1;
          sum_d  = sum_q + fold;
          idle_d = '0;
          if (cnt_d == target_q) state_d = StDone;
        end else begin
          idle_d = idle_q + TW'(1);
          if (idle_d == TW'(TIMEOUT_CYC)) begin
            state_d  = StDone;
            err_to_d = 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      target_q   <= '0;
      cnt_q      <= '0;
      sum_q      <= '0;
      idle_q     <= '0;
      err_code_q <= 1'b0;
      err_to_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      idle_q     <= idle_d;
      err_code_q <= err_code_d;
      err_to_q   <= err_to_d;
      if (accept) wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
      if (pop_ok) rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
    end
  end

  // Storage needs no reset: pop_data is masked while empty.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

`ifdef OFM_CAPTURE_CHK_EN
  logic [15:0]  mis_q, mis_d;
  logic [127:0] exp_beat;

  always_comb begin
    exp_beat = {16{cnt_q[7:0]}};
    mis_d    = mis_q;
    if (start_ok) begin
      mis_d = '0;
    end else if (accept && (wr_data != exp_beat) && (mis_q != 16'hFFFF)) begin
      mis_d = mis_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mis_q <= '0;
    else        mis_q <= mis_d;
  end

  assign mismatch_cnt = mis_q;
`else
  assign mismatch_cnt = '0;
`endif

endmodule

// File: tb/tb_fpga_ofm_capture.sv
// Randomized bench for fpga_ofm_capture against a queue-based transaction model.
module tb_fpga_ofm_capture;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   ifcode = '0;
  logic         wr_val = 1'b0;
  logic [127:0] wr_data = '0;
  logic         pop = 1'b0;
  logic         wr_rdy, empty, busy, done, err_code, err_timeout;
  logic [127:0] pop_data;
  logic [19:0]  word_cnt;
  logic [31:0]  checksum;
  logic [15:0]  mismatch_cnt;

  fpga_ofm_capture dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .ifcode       (ifcode),
    .wr_val       (wr_val),
    .wr_data      (wr_data),
    .wr_rdy       (wr_rdy),
    .pop          (pop),
    .pop_data     (pop_data),
    .empty        (empty),
    .busy         (busy),
    .done         (done),
    .word_cnt     (word_cnt),
    .checksum     (checksum),
    .err_code     (err_code),
    .err_timeout  (err_timeout),
    .mismatch_cnt (mismatch_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: phase 0 idle, 1 arm, 2 capture, 3 done
  int           m_phase;
  logic [127:0] m_fifo[$];
  int           m_cnt, m_target, m_idle, m_mis;
  logic [31:0]  m_sum;
  bit           m_errc, m_errt;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [127:0] pat(input int idx);
    logic [7:0] b;
    b = idx[7:0];
    return {16{b}};
  endfunction

  function automatic logic [31:0] fold(input logic [127:0] d);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 4; i++) r = r ^ d[32*i +: 32];
    return r;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_fifo.delete(); m_cnt = 0; m_target = 0; m_idle = 0;
    m_mis = 0; m_sum = 0; m_errc = 0; m_errt = 0;
  endtask

  task automatic model_step();
    bit accept;
    accept = (m_phase == 2) && wr_val && (m_fifo.size() < 16);
    if (pop && m_fifo.size() > 0) void'(m_fifo.pop_front());
    if (accept) m_fifo.push_back(wr_data);
    case (m_phase)
      0: if (start) begin
        if (ifcode == 1 || ifcode == 2) begin
          m_phase = 1; m_target = 64; m_cnt = 0; m_sum = 0; m_mis = 0;
        end else m_errc = 1;
      end
      1: begin m_phase = 2; m_idle = 0; end
      2: if (accept) begin
`ifdef OFM_CAPTURE_CHK_EN
        if (wr_data != pat(m_cnt) && m_mis < 16'hFFFF) m_mis++;
`endif
        m_cnt++; m_sum = m_sum + fold(wr_data); m_idle = 0;
        if (m_cnt == m_target) m_phase = 3;
      end else begin
        m_idle++;
        if (m_idle == 1024) begin m_phase = 3; m_errt = 1; end
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic check_all();
    check_val("wr_rdy", wr_rdy, (m_phase == 2 && m_fifo.size() < 16));
    check_val("busy", busy, m_phase != 0);
    check_val("done", done, m_phase == 3);
    check_val("empty", empty, m_fifo.size() == 0);
    check_val("pop_data", pop_data, m_fifo.size() > 0 ? m_fifo[0] : 128'd0);
    check_val("word_cnt", word_cnt, m_cnt);
    check_val("checksum", checksum, m_sum);
    check_val("err_code", err_code, m_errc);
    check_val("err_timeout", err_timeout, m_errt);
    check_val("mismatch_cnt", mismatch_cnt, m_mis);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic run_xfer(input int ic, input int vprob, input int pprob, input int pop_after,
                          input int max_beats, input int bad_idx, input int ncyc);
    logic [127:0] d;
    start = 1; ifcode = 4'(ic); wr_val = 0; pop = 0;
    tick();
    start = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (m_phase == 0) break;
      start   = ($urandom_range(15) == 0);
      ifcode  = 4'($urandom);
      wr_val  = (m_cnt < max_beats) && ($urandom_range(99) < vprob);
      d       = pat(m_cnt);
      if (m_cnt == bad_idx) d = d ^ (128'd1 << $urandom_range(127));
      wr_data = d;
      pop     = (c >= pop_after) && ($urandom_range(99) < pprob);
      tick();
    end
    check_val("xfer_end_busy", busy, 0);
    start = 0; wr_val = 0; pop = 1;
    repeat (18) tick();
    pop = 0;
  endtask

  initial begin
    model_reset();
    #3;
    check_all();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    check_all();

    // Full OFM transfer, back-to-back beats
    run_xfer(2, 100, 100, 0, 64, -1, 200);
    check_val("ofm_word_cnt", word_cnt, 64);
    check_val("ofm_mismatch", mismatch_cnt, 0);
    check_val("ofm_err_to", err_timeout, 0);
    check_val("ofm_err_code", err_code, 0);

    // Illegal interface code
    run_xfer(9, 100, 100, 0, 64, -1, 10);
    check_val("bad_ifcode_err", err_code, 1);
    check_val("bad_ifcode_busy", busy, 0);

    // FIFO fills with no reader, then drains one per cycle
    run_xfer(1, 100, 100, 30, 64, -1, 300);
    check_val("flg_word_cnt", word_cnt, 64);

    // Stalled transfer times out
    run_xfer(2, 100, 50, 0, 10, -1, 1200);
    check_val("to_err_timeout", err_timeout, 1);
    check_val("to_word_cnt", word_cnt, 10);

    // Corrupted beat 5
    run_xfer(2, 100, 100, 0, 64, 5, 200);
`ifdef OFM_CAPTURE_CHK_EN
    check_val("corrupt_mismatch", mismatch_cnt, 1);
`else
    check_val("corrupt_mismatch", mismatch_cnt, 0);
`endif

    // Checksum corner beats, then reset mid-transfer
    start = 1; ifcode = 4'd1; tick();
    start = 0; tick();
    wr_val = 1; wr_data = 128'h1; tick();
    check_val("csum_one", checksum, 32'h1);
    wr_data = '1; tick();
    check_val("csum_ones", checksum, 32'h1);
    wr_data = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321; tick();
    wr_val = 0;
    #2;
    rst_n = 0;
    model_reset();
    #1;
    check_all();
    check_val("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1;
    tick();

    // Randomized transfers
    for (int t = 0; t < 20; t++) begin
      int ic;
      case ($urandom_range(3))
        0: ic = 1;
        1: ic = 2;
        default: ic = int'($urandom_range(15));
      endcase
      run_xfer(ic, int'($urandom_range(30, 100)), int'($urandom_range(0, 100)),
               int'($urandom_range(0, 40)), 64,
               ($urandom_range(3) == 0) ? int'($urandom_range(63)) : -1, 2000);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
